// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a per-register busy scoreboard.
// Reads are registered (latency 1) with write-first bypass from the same-cycle
// writeback. The issue stage reserves destinations through rsv_*, and writeback
// clears them. rd_hazard tells the issue stage when a read must stall.
// Optional build macro: REGFILE_R0_ZERO_EN hardwires register 0 to zero and
// makes it never busy.

// One read port: address decode, bypass mux, hazard flag and output register.
module regfile_sb_rdport #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rd_en,
  input  logic [ADDR_W-1:0]              rd_addr,
  input  logic [NREGS-1:0][DATA_W-1:0]   regs_q,
  input  logic [NREGS-1:0]               busy_q,
  input  logic [NREGS-1:0]               wr_dec,
  input  logic [DATA_W-1:0]              wr_data,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_valid,
  output logic                           rd_hazard
);
  logic [NREGS-1:0]  rd_dec;
  logic [DATA_W-1:0] rd_mux;

  // One-hot decode. Addresses >= NREGS match no register, so they read as 0.
  always_comb begin
    rd_dec = '0;
    for (int n = 0; n < NREGS; n++)
      rd_dec[n] = (rd_addr == ADDR_W'(n));
  end

  // Write-first select. wr_dec has the ignored writes (out of range, or a
  // hardwired r0) already removed, so those writes never bypass.
  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NREGS; n++)
      if (rd_dec[n]) rd_mux = wr_dec[n] ? wr_data : regs_q[n];
  end

  // A same-cycle write to the register supplies the data, so it clears the hazard.
  assign rd_hazard = rd_en & (|(rd_dec & busy_q & ~wr_dec));

  // Registered read. Data holds when the port is idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end
endmodule

module regfile_sb #(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 8,
  parameter  int NRD    = 2,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [NRD-1:0]          rd_en,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_valid,
  output logic [NRD-1:0]          rd_hazard,
  input  logic                    rsv_en,
  input  logic [ADDR_W-1:0]       rsv_addr,
  output logic                    rsv_err,
  output logic [NREGS-1:0]        busy,
  output logic [NREGS*DATA_W-1:0] regs
);
`ifdef REGFILE_R0_ZERO_EN
  // r0 accepts no writes and no reservations, so it stays 0 and never becomes busy.
  localparam logic [NREGS-1:0] WR_MASK = {{(NREGS-1){1'b1}}, 1'b0};
`else
  localparam logic [NREGS-1:0] WR_MASK = '1;
`endif

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0]             busy_q;
  logic [NREGS-1:0]             wr_dec;
  logic [NREGS-1:0]             rsv_dec;

  // Write and reserve decodes. Out-of-range and masked addresses decode to nothing.
  always_comb begin
    wr_dec  = '0;
    rsv_dec = '0;
    for (int n = 0; n < NREGS; n++) begin
      wr_dec[n]  = wr_en  && (wr_addr  == ADDR_W'(n));
      rsv_dec[n] = rsv_en && (rsv_addr == ADDR_W'(n));
    end
    wr_dec  = wr_dec  & WR_MASK;
    rsv_dec = rsv_dec & WR_MASK;
  end

  // Register array and scoreboard. A reserve beats a same-cycle writeback,
  // because the newly issued producer now owns the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q  <= '0;
      busy_q  <= '0;
      rsv_err <= 1'b0;
    end else begin
      for (int n = 0; n < NREGS; n++) begin
        if (wr_dec[n]) regs_q[n] <= wr_data;
        if (rsv_dec[n])     busy_q[n] <= 1'b1;
        else if (wr_dec[n]) busy_q[n] <= 1'b0;
      end
      // A double reserve is an error only if no writeback retires the old producer.
      rsv_err <= |(rsv_dec & busy_q & ~wr_dec);
    end
  end

  // Build one read-port instance for each port.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en[i]),
      .rd_addr   (rd_addr[i*ADDR_W +: ADDR_W]),
      .regs_q    (regs_q),
      .busy_q    (busy_q),
      .wr_dec    (wr_dec),
      .wr_data   (wr_data),
      .rd_data   (rd_data[i*DATA_W +: DATA_W]),
      .rd_valid  (rd_valid[i]),
      .rd_hazard (rd_hazard[i])
    );
  end

  assign busy = busy_q;
  assign regs = regs_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb with the default parameters
// (16-bit data, 8 registers, 2 read ports).
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_hazard;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic        rsv_err;
  logic [7:0]  busy;
  logic [127:0] regs;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_hazard(rd_hazard), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(rsv_err),
    .busy(busy), .regs(regs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [1:0]  re;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic        rv;
    logic [2:0]  rva;
    logic [1:0]  hz;   // checked before the edge
    logic [15:0] d0;   // checked after the edge
    logic [15:0] d1;
    logic [1:0]  vld;
    logic [7:0]  bsy;
    logic        err;
  } vec_t;

  vec_t tv[17];

  function automatic vec_t mk(logic rst, logic we, logic [2:0] wa, logic [15:0] wd,
                              logic [1:0] re, logic [2:0] ra0, logic [2:0] ra1,
                              logic rv, logic [2:0] rva, logic [1:0] hz,
                              logic [15:0] d0, logic [15:0] d1, logic [1:0] vld,
                              logic [7:0] bsy, logic err);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra0 = ra0; v.ra1 = ra1;
    v.rv = rv; v.rva = rva; v.hz = hz; v.d0 = d0; v.d1 = d1; v.vld = vld;
    v.bsy = bsy; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [1:0] re, input logic [2:0] ra0,
                       input logic [2:0] ra1, input logic rv, input logic [2:0] rva);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = {ra1, ra0}; rsv_en = rv; rsv_addr = rva;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: rst we wa wd re ra0 ra1 rv rva | hz d0 d1 vld busy err
    tv[0]  = mk(1,1,3,16'hFFFF,2'b11,3,5,1,3, 2'b00,16'h0000,16'h0000,2'b00,8'h00,0);
    tv[1]  = mk(0,0,0,16'h0000,2'b11,3,5,0,0, 2'b00,16'h0000,16'h0000,2'b11,8'h00,0);
    tv[2]  = mk(0,1,3,16'hBEEF,2'b00,0,0,0,0, 2'b00,16'h0000,16'h0000,2'b00,8'h00,0);
    tv[3]  = mk(0,0,0,16'h0000,2'b01,3,0,0,0, 2'b00,16'hBEEF,16'h0000,2'b01,8'h00,0);
    tv[4]  = mk(0,0,0,16'h0000,2'b00,3,0,0,0, 2'b00,16'hBEEF,16'h0000,2'b00,8'h00,0);
    tv[5]  = mk(0,1,2,16'h1234,2'b11,2,2,0,0, 2'b00,16'h1234,16'h1234,2'b11,8'h00,0);
    tv[6]  = mk(0,0,0,16'h0000,2'b00,0,0,1,4, 2'b00,16'h1234,16'h1234,2'b00,8'h10,0);
    tv[7]  = mk(0,0,0,16'h0000,2'b01,4,0,0,0, 2'b01,16'h0000,16'h1234,2'b01,8'h10,0);
    tv[8]  = mk(0,1,4,16'h00AA,2'b11,4,4,0,0, 2'b00,16'h00AA,16'h00AA,2'b11,8'h00,0);
    tv[9]  = mk(0,0,0,16'h0000,2'b10,0,6,1,6, 2'b00,16'h00AA,16'h0000,2'b10,8'h40,0);
    tv[10] = mk(0,0,0,16'h0000,2'b10,0,6,1,6, 2'b10,16'h00AA,16'h0000,2'b10,8'h40,1);
    tv[11] = mk(0,1,6,16'h5555,2'b01,6,0,1,6, 2'b00,16'h5555,16'h0000,2'b01,8'h40,0);
    tv[12] = mk(0,1,6,16'h7777,2'b00,0,0,0,0, 2'b00,16'h5555,16'h0000,2'b00,8'h00,0);
    tv[13] = mk(0,1,2,16'h2222,2'b11,1,2,1,1, 2'b00,16'h0000,16'h2222,2'b11,8'h02,0);
    tv[14] = mk(0,1,5,16'h0505,2'b01,1,0,1,1, 2'b01,16'h0000,16'h2222,2'b01,8'h02,1);
    tv[15] = mk(1,1,7,16'h0001,2'b11,6,2,1,0, 2'b00,16'h0000,16'h0000,2'b00,8'h00,0);
    tv[16] = mk(0,0,0,16'h0000,2'b11,6,3,0,0, 2'b00,16'h0000,16'h0000,2'b11,8'h00,0);

    // Initial reset
    drive(1,0,0,16'h0,2'b00,0,0,0,0);
    tick();
    chk("reset_busy",  32'(busy),     32'h0);
    chk("reset_vld",   32'(rd_valid), 32'h0);
    chk("reset_rdata", rd_data,       32'h0);
    chk("reset_err",   32'(rsv_err),  32'h0);
    chk("reset_regs",  regs[31:0],    32'h0);

    for (int k = 0; k < 17; k++) begin
      drive(tv[k].rst, tv[k].we, tv[k].wa, tv[k].wd, tv[k].re, tv[k].ra0, tv[k].ra1,
            tv[k].rv, tv[k].rva);
      #1;
      chk($sformatf("v%0d_hazard", k), 32'(rd_hazard), 32'(tv[k].hz));
      tick();
      chk($sformatf("v%0d_rd0", k),   32'(rd_data[15:0]),  32'(tv[k].d0));
      chk($sformatf("v%0d_rd1", k),   32'(rd_data[31:16]), 32'(tv[k].d1));
      chk($sformatf("v%0d_valid", k), 32'(rd_valid),       32'(tv[k].vld));
      chk($sformatf("v%0d_busy", k),  32'(busy),           32'(tv[k].bsy));
      chk($sformatf("v%0d_rsverr", k), 32'(rsv_err),       32'(tv[k].err));
    end
    chk("post_reset_regs_hi", regs[127:96], 32'h0);
    chk("post_reset_regs_lo", regs[63:32],  32'h0);

    // Register 0: write FFFF, reserve, and read on both ports in the same cycle
    drive(0,1,0,16'hFFFF,2'b11,0,0,1,0);
    #1;
    chk("r0_hazard", 32'(rd_hazard), 32'h0);
    tick();
`ifdef REGFILE_R0_ZERO_EN
    chk("r0_rd0",  32'(rd_data[15:0]),  32'h0);
    chk("r0_rd1",  32'(rd_data[31:16]), 32'h0);
    chk("r0_busy", 32'(busy),           32'h0);
    chk("r0_regs", 32'(regs[15:0]),     32'h0);
    drive(0,0,0,16'h0,2'b01,0,0,1,0);
    #1;
    chk("r0_hazard2", 32'(rd_hazard), 32'h0);
    tick();
    chk("r0_err2",  32'(rsv_err), 32'h0);
    chk("r0_busy2", 32'(busy),    32'h0);
`else
    chk("r0_rd0",  32'(rd_data[15:0]),  32'hFFFF);
    chk("r0_rd1",  32'(rd_data[31:16]), 32'hFFFF);
    chk("r0_busy", 32'(busy),           32'h01);
    chk("r0_regs", 32'(regs[15:0]),     32'hFFFF);
    drive(0,0,0,16'h0,2'b01,0,0,1,0);
    #1;
    chk("r0_hazard2", 32'(rd_hazard), 32'h1);
    tick();
    chk("r0_err2",  32'(rsv_err), 32'h1);
    chk("r0_busy2", 32'(busy),    32'h01);
`endif
    chk("r0_err_pulse_seen", 32'(rd_valid), 32'h1);

    // The error is a single-cycle pulse, and the debug view shows the top register
    drive(0,1,7,16'hCAFE,2'b00,0,0,0,0);
    tick();
    chk("err_pulse_clear", 32'(rsv_err),      32'h0);
    chk("regs_r7",         32'(regs[127:112]), 32'hCAFE);
    chk("regs_r2",         32'(regs[47:32]),   32'h0);
    drive(0,0,0,16'h0,2'b00,0,0,0,0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
